// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared beat struct (default widths) and round-robin pointer increment
package axis_arb_pkg;
  localparam int AXIS_DATA_W = 8;
  localparam int AXIS_ID_W = 4;
  localparam int AXIS_DEST_W = 4;
  typedef struct packed {
    logic [AXIS_DATA_W-1:0] data;
    logic [AXIS_ID_W-1:0]   id;
    logic [AXIS_DEST_W-1:0] dest;
    logic                   last;
  } axis_beat_t;
  function automatic int rr_next(input int ptr, input int n);
    return ptr == n - 1 ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first set req at or after ptr (wrapping); ports req/ptr in, gnt_valid/gnt_idx out
module rr_pick #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx
);
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) begin
        gnt_valid = 1'b1;
        gnt_idx = W'((int'(ptr) + k) % N);
      end
  end
endmodule

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: NUM_CH-to-1 AXI4-Stream round-robin merge (s_* slaves, m_* master, m_tsrc = source); AXIS_ARB_PKT_LOCK_EN holds grant for a whole packet
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = AXIS_DATA_W,
  parameter int ID_W = AXIS_ID_W,
  parameter int DEST_W = AXIS_DEST_W,
  localparam int SRC_W = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] s_tdata,
  input  logic [NUM_CH-1:0]        s_tvalid,
  input  logic [NUM_CH*ID_W-1:0]   s_tid,
  input  logic [NUM_CH*DEST_W-1:0] s_tdest,
  input  logic [NUM_CH-1:0]        s_tlast,
  output logic [NUM_CH-1:0]        s_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic                     m_tvalid,
  output logic [ID_W-1:0]          m_tid,
  output logic [DEST_W-1:0]        m_tdest,
  output logic                     m_tlast,
  output logic [SRC_W-1:0]         m_tsrc,
  input  logic                     m_tready
);
  axis_beat_t beat_q, beat_d;
  logic m_tvalid_q, m_tvalid_d, locked_q, locked_d;
  logic [SRC_W-1:0] tsrc_q, tsrc_d, rr_ptr_q, rr_ptr_d, grant_idx_q, grant_idx_d, pick_idx, g;
  logic pick_v, gnt_v, ld_en, xfer;
  rr_pick #(.N(NUM_CH)) u_pick (
    .req(s_tvalid),
    .ptr(rr_ptr_q),
    .gnt_valid(pick_v),
    .gnt_idx(pick_idx)
  );
  always_comb begin
    ld_en = !m_tvalid_q || m_tready;
    gnt_v = locked_q || pick_v;
    g = locked_q ? grant_idx_q : pick_idx;
    xfer = gnt_v && ld_en && s_tvalid[g];
    // ready is held low while reset is asserted even though ld_en is already 1
    s_tready = (gnt_v && ld_en && !rst) ? NUM_CH'(1) << g : '0;
    beat_d = xfer ? {s_tdata[g*DATA_W +: DATA_W], s_tid[g*ID_W +: ID_W], s_tdest[g*DEST_W +: DEST_W], s_tlast[g]} : beat_q;
    tsrc_d = xfer ? g : tsrc_q;
    m_tvalid_d = xfer || (m_tvalid_q && !ld_en);
`ifdef AXIS_ARB_PKT_LOCK_EN
    locked_d = xfer ? !s_tlast[g] : locked_q;
    grant_idx_d = xfer ? g : grant_idx_q;
    rr_ptr_d = (xfer && s_tlast[g]) ? SRC_W'(rr_next(int'(g), NUM_CH)) : rr_ptr_q;
`else
    locked_d = 1'b0;
    grant_idx_d = grant_idx_q;
    rr_ptr_d = xfer ? SRC_W'(rr_next(int'(g), NUM_CH)) : rr_ptr_q;
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      beat_q <= '0;
      m_tvalid_q <= 1'b0;
      tsrc_q <= '0;
      rr_ptr_q <= '0;
      locked_q <= 1'b0;
      grant_idx_q <= '0;
    end else begin
      beat_q <= beat_d;
      m_tvalid_q <= m_tvalid_d;
      tsrc_q <= tsrc_d;
      rr_ptr_q <= rr_ptr_d;
      locked_q <= locked_d;
      grant_idx_q <= grant_idx_d;
    end
  assign m_tdata = beat_q.data;
  assign m_tid = beat_q.id;
  assign m_tdest = beat_q.dest;
  assign m_tlast = beat_q.last;
  assign m_tvalid = m_tvalid_q;
  assign m_tsrc = tsrc_q;
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: directed scenarios plus randomized traffic checked against a behavioural model
module tb_axis_rr_arbiter;
  localparam int N = 4, DW = 8, IW = 4, TW = 4, SW = 2;
  logic clk = 1'b0, rst;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0] s_tvalid, s_tlast, s_tready, hs;
  logic [N*IW-1:0] s_tid;
  logic [N*TW-1:0] s_tdest;
  logic [DW-1:0] m_tdata;
  logic [IW-1:0] m_tid;
  logic [TW-1:0] m_tdest;
  logic [SW-1:0] m_tsrc;
  logic m_tvalid, m_tlast, m_tready;
  int checks = 0, errors = 0;
  logic mv, ml;
  logic [DW-1:0] md;
  logic [IW-1:0] mi;
  logic [TW-1:0] mt;
  logic [SW-1:0] ms;
  int rr, lk, gi, e_gv, e_g, e_ld;
  logic [N-1:0] e_ready;
  always #5 clk = ~clk;
  axis_rr_arbiter dut (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tid(s_tid),
    .s_tdest(s_tdest), .s_tlast(s_tlast), .s_tready(s_tready), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tid(m_tid), .m_tdest(m_tdest), .m_tlast(m_tlast),
    .m_tsrc(m_tsrc), .m_tready(m_tready)
  );
  task model_rst();
    mv = 0; ml = 0; md = 0; mi = 0; mt = 0; ms = 0; rr = 0; lk = 0; gi = 0;
  endtask
  task model_comb();
    e_gv = 0;
    e_g = 0;
    if (lk != 0) begin
      e_gv = 1;
      e_g = gi;
    end else
      for (int k = 0; k < N; k++)
        if (e_gv == 0 && s_tvalid[(rr + k) % N]) begin
          e_gv = 1;
          e_g = (rr + k) % N;
        end
    e_ld = (!mv || m_tready) ? 1 : 0;
    e_ready = (e_gv != 0 && e_ld != 0) ? N'(1) << e_g : '0;
  endtask
  task model_clk();
    if (e_ready != 0 && s_tvalid[e_g]) begin
      mv = 1;
      md = s_tdata[e_g*DW +: DW];
      mi = s_tid[e_g*IW +: IW];
      mt = s_tdest[e_g*TW +: TW];
      ml = s_tlast[e_g];
      ms = SW'(e_g);
`ifdef AXIS_ARB_PKT_LOCK_EN
      if (!s_tlast[e_g]) begin
        lk = 1;
        gi = e_g;
      end else begin
        lk = 0;
        rr = (e_g + 1) % N;
      end
`else
      rr = (e_g + 1) % N;
`endif
    end else if (e_ld != 0) mv = 0;
  endtask
  task tick();
    model_comb();
    model_clk();
    @(posedge clk);
    #1;
  endtask
  task set_ch(input int c, input logic v, input logic [DW-1:0] d, input logic l);
    s_tvalid[c] = v;
    s_tdata[c*DW +: DW] = d;
    s_tlast[c] = l;
    s_tid[c*IW +: IW] = IW'(c);
    s_tdest[c*TW +: TW] = TW'(N - 1 - c);
  endtask
  task do_reset();
    rst = 1'b1;
    s_tvalid = '0;
    s_tlast = '0;
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_rst();
  endtask
  task test_reset();
    for (int c = 0; c < N; c++) set_ch(c, 1'b1, 8'h10 + 8'(c), 1'b1);
    m_tready = 1'b1;
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid cyc%0d: got %b want 0", i, m_tvalid); end
      checks++; if (s_tready !== 4'b0000) begin errors++; $display("FAIL reset_tready cyc%0d: got %b want 0000", i, s_tready); end
    end
    rst = 1'b0;
    model_rst();
    #1;
    checks++; if (s_tready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b want 0001", s_tready); end
    tick();
    checks++; if (m_tvalid !== 1'b1 || m_tsrc !== 2'd0 || m_tdata !== 8'h10) begin errors++; $display("FAIL reset_first_beat: got v=%b src=%0d d=%h want v=1 src=0 d=10", m_tvalid, m_tsrc, m_tdata); end
  endtask
  task test_fair_rotation();
    do_reset();
    for (int c = 0; c < N; c++) set_ch(c, 1'b1, 8'h10 + 8'(c), 1'b1);
    #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL fair_latency: got tvalid %b want 0 before first edge", m_tvalid); end
    for (int b = 0; b < 6; b++) begin
      checks++; if (s_tready !== N'(1) << (b % N)) begin errors++; $display("FAIL fair_tready beat%0d: got %b want %b", b, s_tready, N'(1) << (b % N)); end
      tick();
      checks++; if (m_tvalid !== 1'b1 || m_tsrc !== SW'(b % N) || m_tdata !== 8'h10 + 8'(b % N)) begin errors++; $display("FAIL fair_beat%0d: got v=%b src=%0d d=%h want v=1 src=%0d d=%h", b, m_tvalid, m_tsrc, m_tdata, b % N, 8'h10 + 8'(b % N)); end
    end
  endtask
  task test_sparse();
    do_reset();
    set_ch(2, 1'b1, 8'h22, 1'b1);
    #1 tick();
    checks++; if (m_tsrc !== 2'd2 || m_tdata !== 8'h22) begin errors++; $display("FAIL sparse_ch2: got src=%0d d=%h want src=2 d=22", m_tsrc, m_tdata); end
    set_ch(2, 1'b0, 8'h00, 1'b1);
    set_ch(1, 1'b1, 8'h21, 1'b1);
    set_ch(3, 1'b1, 8'h23, 1'b1);
    #1;
    checks++; if (s_tready !== 4'b1000) begin errors++; $display("FAIL sparse_tready3: got %b want 1000", s_tready); end
    tick();
    checks++; if (m_tsrc !== 2'd3 || m_tdata !== 8'h23) begin errors++; $display("FAIL sparse_ch3: got src=%0d d=%h want src=3 d=23", m_tsrc, m_tdata); end
    set_ch(3, 1'b0, 8'h00, 1'b1);
    #1 tick();
    checks++; if (m_tsrc !== 2'd1 || m_tdata !== 8'h21) begin errors++; $display("FAIL sparse_ch1: got src=%0d d=%h want src=1 d=21", m_tsrc, m_tdata); end
  endtask
  task test_backpressure();
    do_reset();
    m_tready = 1'b0;
    set_ch(0, 1'b1, 8'hA5, 1'b1);
    #1;
    checks++; if (s_tready !== 4'b0001) begin errors++; $display("FAIL bp_first_ready: got %b want 0001", s_tready); end
    tick();
    set_ch(0, 1'b1, 8'h5A, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (s_tready !== 4'b0000) begin errors++; $display("FAIL bp_ready_hold%0d: got %b want 0000", i, s_tready); end
      checks++; if (m_tvalid !== 1'b1 || m_tdata !== 8'hA5 || m_tsrc !== 2'd0) begin errors++; $display("FAIL bp_hold%0d: got v=%b d=%h src=%0d want v=1 d=a5 src=0", i, m_tvalid, m_tdata, m_tsrc); end
      tick();
    end
    m_tready = 1'b1;
    #1;
    checks++; if (s_tready !== 4'b0001) begin errors++; $display("FAIL bp_release_ready: got %b want 0001", s_tready); end
    tick();
    checks++; if (m_tvalid !== 1'b1 || m_tdata !== 8'h5A) begin errors++; $display("FAIL bp_no_bubble: got v=%b d=%h want v=1 d=5a", m_tvalid, m_tdata); end
    set_ch(0, 1'b0, 8'h00, 1'b1);
    #1 tick();
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL bp_drain: got tvalid %b want 0", m_tvalid); end
  endtask
  task test_packet_lock();
    logic [DW-1:0] exp_d [5];
    int p0, p1;
`ifdef AXIS_ARB_PKT_LOCK_EN
    exp_d = '{8'hC0, 8'hC1, 8'hC2, 8'hD0, 8'hD1};
`else
    exp_d = '{8'hC0, 8'hD0, 8'hC1, 8'hD1, 8'hC2};
`endif
    do_reset();
    p0 = 0;
    p1 = 0;
    for (int b = 0; b < 5; b++) begin
      set_ch(0, p0 < 3, 8'hC0 + 8'(p0), p0 == 2);
      set_ch(1, 1'b1, 8'hD0 + 8'(p1), 1'b1);
      #1 hs = s_tready & s_tvalid;
      tick();
      if (hs[0]) p0++;
      if (hs[1]) p1++;
      checks++; if (m_tvalid !== 1'b1 || m_tdata !== exp_d[b] || m_tsrc !== SW'(exp_d[b][4])) begin errors++; $display("FAIL pkt_beat%0d: got v=%b d=%h src=%0d want v=1 d=%h src=%0d", b, m_tvalid, m_tdata, m_tsrc, exp_d[b], exp_d[b][4]); end
    end
  endtask
  task test_async_reset();
    do_reset();
    set_ch(1, 1'b1, 8'h31, 1'b0);
    #1 tick();
    checks++; if (m_tvalid !== 1'b1 || m_tsrc !== 2'd1) begin errors++; $display("FAIL arst_beat1: got v=%b src=%0d want v=1 src=1", m_tvalid, m_tsrc); end
    set_ch(1, 1'b1, 8'h32, 1'b1);
    set_ch(0, 1'b1, 8'h01, 1'b1);
    set_ch(3, 1'b1, 8'h03, 1'b1);
    #1 rst = 1'b1;
    #1;
    checks++; if (m_tvalid !== 1'b0 || s_tready !== 4'b0000) begin errors++; $display("FAIL arst_immediate: got v=%b ready=%b want v=0 ready=0000", m_tvalid, s_tready); end
    rst = 1'b0;
    model_rst();
    #1;
    checks++; if (s_tready !== 4'b0001) begin errors++; $display("FAIL arst_regrant: got ready=%b want 0001", s_tready); end
    tick();
    checks++; if (m_tvalid !== 1'b1 || m_tsrc !== 2'd0 || m_tdata !== 8'h01) begin errors++; $display("FAIL arst_after: got v=%b src=%0d d=%h want v=1 src=0 d=01", m_tvalid, m_tsrc, m_tdata); end
  endtask
  task test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N; c++)
        if (!s_tvalid[c] && $urandom_range(0, 2) != 0) begin
          set_ch(c, 1'b1, 8'($urandom), 1'($urandom_range(0, 1)));
          s_tid[c*IW +: IW] = 4'($urandom);
          s_tdest[c*TW +: TW] = 4'($urandom);
        end
      m_tready = $urandom_range(0, 3) != 0;
      #1 model_comb();
      checks++; if (s_tready !== e_ready) begin errors++; $display("FAIL rand_tready cyc%0d: got %b want %b", i, s_tready, e_ready); end
      checks++; if (m_tvalid !== mv) begin errors++; $display("FAIL rand_tvalid cyc%0d: got %b want %b", i, m_tvalid, mv); end
      if (mv) begin
        checks++; if ({m_tdata, m_tid, m_tdest, m_tlast, m_tsrc} !== {md, mi, mt, ml, ms}) begin errors++; $display("FAIL rand_beat cyc%0d: got d=%h id=%h dst=%h l=%b src=%0d want d=%h id=%h dst=%h l=%b src=%0d", i, m_tdata, m_tid, m_tdest, m_tlast, m_tsrc, md, mi, mt, ml, ms); end
      end
      hs = s_tready & s_tvalid;
      tick();
      for (int c = 0; c < N; c++) if (hs[c]) s_tvalid[c] = 1'b0;
    end
  endtask
  initial begin
    rst = 1'b0;
    s_tvalid = '0;
    s_tlast = '0;
    s_tdata = '0;
    s_tid = '0;
    s_tdest = '0;
    m_tready = 1'b1;
    model_rst();
    test_reset();
    test_fair_rotation();
    test_sparse();
    test_backpressure();
    test_packet_lock();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
